// File: rtl/sha256_round_sequencer.sv
// SHA-256 block sequencer: loads IV into the A..H bank, steps 64 rounds,
// then adds the final working variables back onto the IV to form the digest.
module sha256_round_sequencer #(
   parameter int ROUNDS = 64,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [255:0]      iv,
   input  logic [255:0]      vars_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_var,
   output logic              round_en,
   output logic [5:0]        round_idx,
   output logic              busy,
   output logic              done,
   output logic [255:0]      digest
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL
   } state_t;

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

   state_t       state;
   state_t       state_nx;
   logic [2:0]   k;
   logic [2:0]   k_nx;
   logic [5:0]   t;
   logic [5:0]   t_nx;
   logic [255:0] iv_q;
   logic [255:0] iv_sh;
   logic [255:0] sum;
   logic [255:0] digest_q;
   logic         done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         k        <= '0;
         t        <= '0;
         iv_q     <= '0;
         digest_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         k      <= k_nx;
         t      <= t_nx;
         done_q <= (state == FINAL);
         if (state == IDLE && start) begin
            iv_q <= iv;
         end
         if (state == FINAL) begin
            digest_q <= sum;
         end
      end
   end

   // Per-word modular add; carries never cross word boundaries.
   always_comb begin
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i*32 +: 32] = iv_q[i*32 +: 32] + vars_in[i*32 +: 32];
      end
   end

   assign iv_sh = iv_q << {k, 5'd0};

   always_comb begin
      state_nx  = state;
      k_nx      = k;
      t_nx      = t;
      mem_addr  = ADDR_W'(1);
      mem_var   = vars_in[255:224];
      round_en  = 1'b0;
      round_idx = '0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = LOAD;
               k_nx     = '0;
            end
         end
         LOAD: begin
            busy     = 1'b1;
            mem_addr = ADDR_W'(k) + ADDR_W'(1);
            mem_var  = iv_sh[255:224];
            if (k == 3'd7) begin
               state_nx = ROUND;
               k_nx     = '0;
               t_nx     = '0;
            end else begin
               k_nx = k + 3'd1;
            end
         end
         ROUND: begin
            busy      = 1'b1;
            mem_addr  = '0;
            round_en  = 1'b1;
            round_idx = t;
            if (t == T_LAST) begin
               state_nx = FINAL;
               t_nx     = '0;
            end else begin
               t_nx = t + 6'd1;
            end
         end
         FINAL: begin
            busy     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign done   = done_q;
   assign digest = digest_q;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Randomised bench for sha256_round_sequencer: phase-based reference model,
// digest scoreboard queue and a per-cycle output monitor.
module tb_sha256_round_sequencer;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [255:0] iv;
   logic [255:0] vars_in;
   logic [3:0]   mem_addr;
   logic [31:0]  mem_var;
   logic         round_en;
   logic [5:0]   round_idx;
   logic         busy;
   logic         done;
   logic [255:0] digest;

   int n_chk  = 0;
   int n_fail = 0;

   sha256_round_sequencer #(.ROUNDS(64), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .iv        (iv),
      .vars_in   (vars_in),
      .mem_addr  (mem_addr),
      .mem_var   (mem_var),
      .round_en  (round_en),
      .round_idx (round_idx),
      .busy      (busy),
      .done      (done),
      .digest    (digest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // vars_in is either random every cycle or one constant replicated per word
   bit          vars_rand = 1'b1;
   logic [31:0] vars_c    = '0;

   initial begin
      vars_in = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < 8; i++) begin
            vars_in[i*32 +: 32] = vars_rand ? $urandom : vars_c;
         end
      end
   end

   // Reference model: ph = cycles since an accepted start (0..72), -1 idle.
   int           ph    = -1;
   bit           exp_done = 1'b0;
   logic [255:0] iv_m  = '0;
   logic [255:0] dig_m = '0;
   logic [255:0] digq[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       = -1;
         exp_done = 1'b0;
         dig_m    = '0;
         digq.delete();
      end else begin
         exp_done = 1'b0;
         if (ph == 72) begin
            for (int i = 0; i < 8; i++) begin
               dig_m[i*32 +: 32] = iv_m[i*32 +: 32] + vars_in[i*32 +: 32];
            end
            digq.push_back(dig_m);
            exp_done = 1'b1;
            ph       = -1;
         end else if (ph >= 0) begin
            ph++;
         end else if (start) begin
            iv_m = iv;
            ph   = 0;
         end
      end
   end

   // Monitor: per-cycle sequencing outputs plus digest scoreboard
   always @(negedge clk) begin
      logic [3:0]  e_addr;
      logic [31:0] e_var;
      bit          e_ren;
      logic [5:0]  e_idx;
      bit          e_busy;
      bit          var_chk;
      e_addr  = 4'd1;
      e_var   = vars_in[255:224];
      e_ren   = 1'b0;
      e_idx   = '0;
      e_busy  = (ph >= 0);
      var_chk = 1'b1;
      if (ph >= 0 && ph < 8) begin
         e_addr = 4'(ph + 1);
         e_var  = iv_m[255 - 32*ph -: 32];
      end else if (ph >= 8 && ph < 72) begin
         e_addr  = 4'd0;
         e_ren   = 1'b1;
         e_idx   = 6'(ph - 8);
         var_chk = 1'b0;
      end
      chk("mem_addr", 256'(mem_addr), 256'(e_addr));
      if (var_chk) chk("mem_var", 256'(mem_var), 256'(e_var));
      chk("round_en", 256'(round_en), 256'(e_ren));
      chk("round_idx", 256'(round_idx), 256'(e_idx));
      chk("busy", 256'(busy), 256'(e_busy));
      chk("done", 256'(done), 256'(exp_done));
      if (done) begin
         if (digq.size() == 0) begin
            chk("digest_sb_empty", 256'(digq.size()), 256'd1);
         end else begin
            chk("digest_sb", digest, digq.pop_front());
         end
      end
      chk("digest_hold", digest, dig_m);
   end

   task automatic launch(input logic [255:0] v);
      iv    = v;
      start = 1'b1;
   endtask

   // start must already be high; counts edges from acceptance to done
   task automatic wait_done(input string nm);
      int n;
      bit seen;
      @(posedge clk);
      #2 start = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 120) begin
         @(posedge clk);
         n++;
         #1;
         if (done) seen = 1'b1;
      end
      chk(nm, 256'(n), 256'd73);
   endtask

   task automatic wait_idx(input logic [5:0] idx, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         n++;
         if (round_en && round_idx == idx) ok = 1'b1;
      end
      chk("wait_round_idx", 256'(ok), 256'd1);
   endtask

   task automatic poke_start(input logic [255:0] v);
      bit ok;
      wait_idx(6'd10, ok);
      if (ok) begin
         #1 launch(v);
         @(posedge clk);
         #2 start = 1'b0;
      end
   endtask

   task automatic rnd_iv(output logic [255:0] v);
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_addr"}, 256'(mem_addr), 256'd1);
      chk({nm, "_var"}, 256'(mem_var), 256'(vars_in[255:224]));
      chk({nm, "_busy"}, 256'(busy), 256'd0);
      chk({nm, "_done"}, 256'(done), 256'd0);
      chk({nm, "_ren"}, 256'(round_en), 256'd0);
      chk({nm, "_idx"}, 256'(round_idx), 256'd0);
      chk({nm, "_digest"}, digest, 256'd0);
   endtask

   initial begin
      logic [255:0] v;
      logic [255:0] std_iv;
      bit           ok;
      std_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      rst_n = 1'b0;
      start = 1'b0;
      iv    = '0;
      #13;
      check_reset_vals("por");
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // standard IV, random bank contents
      #2 launch(std_iv);
      wait_done("lat_std");

      // start in the done cycle; all-ones IV plus one wraps to zero
      vars_rand = 1'b0;
      vars_c    = 32'h1;
      launch({8{32'hffffffff}});
      wait_done("lat_back2back");
      chk("digest_wrap", digest, 256'd0);

      // ignored start mid-round with a different IV
      @(posedge clk);
      vars_c = 32'h2;
      #2 launch({8{32'h1}});
      fork
         wait_done("lat_ignore");
         poke_start({8{32'hdeadbeef}});
      join
      chk("digest_orig_iv", digest, {8{32'h3}});

      // asynchronous abort at round 30
      vars_rand = 1'b1;
      @(posedge clk);
      rnd_iv(v);
      #2 launch(v);
      @(posedge clk);
      #2 start = 1'b0;
      wait_idx(6'd30, ok);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("abort");
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      for (int b = 0; b < 4; b++) begin
         rnd_iv(v);
         #2 launch(v);
         wait_done("lat_rand");
         repeat ($urandom_range(3, 0)) @(posedge clk);
      end
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/sha256_round_sequencer.md
Name: sha256_round_sequencer

Overview:
- Sequences the SHA-256 working-variable register bank (A..H, one-word address write plus bulk update) for one 512-bit block compression.
- On start: loads the 8 initial hash words through the single-word write port, runs 64 bulk-update round cycles while publishing the round index for K/W lookup, then forms digest = IV + final A..H (mod 2^32 per word).
- Sits between the top-level block controller and the working-variable bank plus round logic.

Parameters:
- ROUNDS, 64, number of compression rounds; the round counter width is fixed at 6 bits.
- ADDR_W, 4, width of the bank address bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin compression; sampled only in IDLE.
- iv  in  256  initial hash {H0..H7}, H0 in [255:224]; captured on the accepted start.
- vars_in  in  256  current bank contents {A..H}, A in [255:224].
- mem_addr  out  ADDR_W  bank address: 1..8 writes A..H; 0 is a bulk round update.
- mem_var  out  32  word written when mem_addr is 1..8.
- round_en  out  1  high during round cycles.
- round_idx  out  6  current round t, 0..63.
- busy  out  1  high from LOAD through FINAL.
- done  out  1  one-cycle pulse when digest is valid.
- digest  out  256  {H0'..H7'}, held until the next done.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; load and round counters 0; IV register 0.
  - digest=0, done=0, busy=0, round_en=0, round_idx=0.
  - mem_addr=1, mem_var=vars_in[255:224] (hold encoding).
- Hold encoding: every bank address except 1..8 triggers a bulk update, so in all non-LOAD/non-ROUND states drive mem_addr=1 and mem_var=vars_in A word. A is rewritten with itself and B..H stay unchanged. mem_addr=0 is never driven outside ROUND.
- IDLE: on start=1, capture iv and go to LOAD with k=0.
- LOAD (8 cycles, k=0..7):
  - mem_addr=k+1; mem_var=IV word k (word 0 = [255:224]).
  - After k=7, go to ROUND with t=0.
- ROUND (ROUNDS cycles):
  - mem_addr=0, round_en=1, round_idx=t; t increments each cycle.
  - After t=63, go to FINAL. round_idx never wraps within a block.
- FINAL (1 cycle):
  - Hold encoding; vars_in now holds the post-round-63 values.
  - At the closing edge: digest word i <= IV word i + vars_in word i, truncated to 32 bits (carry discarded, no cross-word carry); done <= 1; return to IDLE.
- done is high for exactly one cycle, the first IDLE cycle. A start in that cycle is accepted and done still deasserts next cycle.
- Latency: with start sampled at edge E0, done and digest update at edge E0+73 (8 LOAD + 64 ROUND + 1 FINAL).
- busy=1 in LOAD, ROUND and FINAL. start while busy is ignored, with no queuing.
- Reset mid-operation aborts immediately to the reset values above, including digest clearing to 0. Bank contents are the bank's own concern.
- All outputs except digest and done are decoded combinationally from state and counters; digest and done are registered.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs reach reset values without a clock edge; mem_addr=1, busy=0, digest=0.
- Load: iv = standard H0..H7 (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19), pulse start -> the next 8 cycles show mem_addr 1..8 with those words in order and busy=1.
- Rounds: after load -> 64 cycles with mem_addr=0, round_en=1, round_idx 0,1,...,63; then FINAL with mem_addr=1 and mem_var = vars_in A; done exactly 73 edges after start.
- Digest arithmetic and wrap: iv all 0xFFFFFFFF, vars_in forced to 0x00000001 per word in FINAL -> digest all 0x00000000. iv all 0x00000001 with vars_in all 0x00000002 -> digest all 0x00000003.
- Start ignored: pulse start at round_idx=10 with a different iv -> sequence is unaffected and digest uses the original iv. Start in the done cycle -> new LOAD begins next cycle.
- Abort: rst_n low at round_idx=30 -> IDLE, digest=0, no done. A fresh start then completes normally in 73 cycles.
